// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback controller.
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    // Requester ids double as grant bit positions and priority pointer values
    localparam int REQ_EX  = 0;
    localparam int REQ_MEM = 1;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. The pointer names the requester that
// wins on contention and moves to the loser after every grant.
module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       pri
);
    import regfile_pkg::*;

    logic pri_reg;
    logic pri_next;

    // Grant: a lone requester wins outright, contention is settled by the pointer
    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (pri_reg == 1'(REQ_MEM)) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Pointer update: after a grant the other requester gets priority
    always_comb begin
        pri_next = pri_reg;
        if (|gnt) begin
            pri_next = gnt[REQ_EX] ? 1'(REQ_MEM) : 1'(REQ_EX);
        end
    end

    // Priority pointer register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pri_reg <= 1'(REQ_EX);
        end else begin
            pri_reg <= pri_next;
        end
    end

    assign pri = pri_reg;

endmodule

// File: rtl/regfile_wb_controller.sv
// Owner of the register file write port: zero-clears every register after
// reset, then arbitrates EX/MEM writebacks and tracks pending writes.
module regfile_wb_controller #(
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ex_valid,
    output logic                ex_ready,
    input  logic [ADDR_W-1:0]   ex_addr,
    input  logic [DATA_W-1:0]   ex_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_data,
    input  logic                iss_valid,
    input  logic [ADDR_W-1:0]   iss_addr,
    output logic                enc,
    output logic [ADDR_W-1:0]   addrc,
    output logic [DATA_W-1:0]   datac,
    output logic                init_done,
    output logic [NUM_REGS-1:0] pending
);
    import regfile_pkg::*;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   clr_cnt_reg, clr_cnt_next;
    logic                init_done_reg;
    logic                enc_reg;
    logic [ADDR_W-1:0]   addrc_reg;
    logic [DATA_W-1:0]   datac_reg;
    logic [NUM_REGS-1:0] pending_reg, pending_next;

    logic                run;
    logic [1:0]          gnt;
    logic                rr_pri;
    logic                acc;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_data;

    assign run = (state_reg == ST_RUN);

    // Arbitration is only open once the clear sequence has finished
    rr_arbiter2 u_arb (
        .clock  (clock),
        .reset  (reset),
        .enable (run),
        .req    ({mem_valid, ex_valid}),
        .gnt    (gnt),
        .pri    (rr_pri)
    );

    assign ex_ready  = gnt[REQ_EX];
    assign mem_ready = gnt[REQ_MEM];
    assign acc       = |gnt;
    assign acc_addr  = gnt[REQ_MEM] ? mem_addr : ex_addr;
    assign acc_data  = gnt[REQ_MEM] ? mem_data : ex_data;

    // Next state: walk every register once, then hand the port to the requesters
    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        if (state_reg == ST_CLEAR) begin
            clr_cnt_next = clr_cnt_reg + 1'b1;
            if (clr_cnt_reg == ADDR_W'(NUM_REGS - 1)) begin
                state_next = ST_RUN;
            end
        end
    end

    // State, clear counter and sticky init flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_CLEAR;
            clr_cnt_reg   <= '0;
            init_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            clr_cnt_reg   <= clr_cnt_next;
            init_done_reg <= init_done_reg | (state_next == ST_RUN);
        end
    end

    // Registered write port: clear writes, or the accepted request; r0 writes are suppressed
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enc_reg   <= 1'b0;
            addrc_reg <= '0;
            datac_reg <= '0;
        end else if (!run) begin
            enc_reg   <= 1'b1;
            addrc_reg <= clr_cnt_reg;
            datac_reg <= '0;
        end else begin
            enc_reg <= acc && (acc_addr != '0);
            if (acc) begin
                addrc_reg <= acc_addr;
                datac_reg <= acc_data;
            end
        end
    end

    // Scoreboard next value per register: an issue sets, an accept clears, set wins
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_sb
            if (gi == 0) begin : g_r0
                assign pending_next[gi] = 1'b0;
            end else begin : g_rn
                assign pending_next[gi] =
                    (run && iss_valid && (iss_addr == ADDR_W'(gi))) ? 1'b1 :
                    (acc && (acc_addr == ADDR_W'(gi)))              ? 1'b0 :
                                                                      pending_reg[gi];
            end
        end
    endgenerate

    // Scoreboard register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign enc       = enc_reg;
    assign addrc     = addrc_reg;
    assign datac     = datac_reg;
    assign init_done = init_done_reg;
    assign pending   = pending_reg;

endmodule

// File: doc/regfile_wb_controller.md
Name: regfile_wb_controller

Overview:
Owns the single write port (enc/addrc/datac) of the 32x32 register file. After reset it sequences a full zero-clear of every register, because the register file has no reset of its own. It then shares the write port between two writeback requesters, EX (ALU result) and MEM (load result), using valid/ready handshakes and round-robin priority. It also keeps a pending-write scoreboard that decode uses for stall decisions.

Parameters:
ADDR_W, 5, register address width
DATA_W, 32, register data width
NUM_REGS, 32, registers to clear; must equal 2**ADDR_W

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
ex_valid  in  1  EX writeback request
ex_ready  out  1  EX request accepted this cycle
ex_addr  in  ADDR_W  EX destination register
ex_data  in  DATA_W  EX write data
mem_valid  in  1  MEM writeback request
mem_ready  out  1  MEM request accepted this cycle
mem_addr  in  ADDR_W  MEM destination register
mem_data  in  DATA_W  MEM write data
iss_valid  in  1  decode issued an instruction that will write iss_addr
iss_addr  in  ADDR_W  destination of the issued instruction
enc  out  1  register file write enable
addrc  out  ADDR_W  register file write address
datac  out  DATA_W  register file write data
init_done  out  1  clear sequence complete; register file usable
pending  out  NUM_REGS  bit i set means a write to register i is outstanding

Behaviour:
- Reset (asynchronous, active-high):
  - state=CLEAR, clr_cnt=0, rr_pri=EX.
  - enc=0, addrc=0, datac=0, init_done=0, pending=0.
  - ex_ready=0, mem_ready=0.
- Reset asserted mid-operation:
  - Any accepted-but-unpresented write is dropped.
  - The clear sequence restarts from register 0.
- enc, addrc and datac are registered outputs. A write accepted or generated in cycle N appears on the port in cycle N+1.
- CLEAR state:
  - Each cycle drives a write of datac=0 to addrc=clr_cnt, with enc=1. Register 0 is included.
  - clr_cnt increments each cycle. Exactly NUM_REGS consecutive enc pulses occur, to addresses 0..NUM_REGS-1 in order.
  - After generating the address NUM_REGS-1 write, go to RUN.
  - init_done goes to 1 in the first RUN cycle and stays 1 until reset.
  - ex_ready=mem_ready=0 throughout CLEAR. iss_valid is ignored during CLEAR.
- RUN state, grant rules:
  - ready outputs are combinational from the valid inputs and rr_pri.
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester named by rr_pri gets ready=1; the other gets 0.
  - After any grant, rr_pri points to the requester that was not granted.
  - No valid: rr_pri is unchanged and the next port cycle has enc=0.
- RUN state, requester rule: valid and addr/data must be held stable until ready=1. The controller never drops a held request.
- Accepted write with addr==0: the handshake completes but the next port cycle has enc=0. Register 0 stays zero.
- Accepted write with addr!=0: the next port cycle has enc=1, addrc=addr, datac=data.
- Scoreboard update (registered):
  - In RUN, iss_valid with iss_addr!=0 sets pending[iss_addr].
  - A handshake accept (RUN only) clears pending[addr].
  - Set and clear of the same bit in the same cycle: set wins, because a new producer is in flight.
  - Bit 0 is always 0.
  - No check is made against duplicate writes; an accept clears the bit even if it was already clear.
- Throughput: one write per cycle sustained. Requester latency from accept to port is 1 cycle.

Decomposition:
- Shared package regfile_pkg holds:
  - ADDR_W, DATA_W, NUM_REGS.
  - State enum {ST_CLEAR, ST_RUN}.
  - Requester id constants {REQ_EX=0, REQ_MEM=1}.
- One sub-module, rr_arbiter2: two-requester round-robin with inputs req[1:0] and enable, outputs gnt[1:0] and a registered priority pointer. The top module handles CLEAR sequencing, port registers and the scoreboard.

Test Plan:
- Release reset, hold all valids low -> 32 consecutive enc=1 cycles at addrc=0..31 with datac=0; init_done=1 in the next cycle; ex_ready stays 0 until then.
- RUN: ex_valid with ex_addr=5, ex_data=0xDEADBEEF -> ex_ready=1 the same cycle; next cycle enc=1, addrc=5, datac=0xDEADBEEF.
- RUN: ex_valid and mem_valid held for 4 cycles (ex addr 3 and mem addr 4) with rr_pri=EX -> grants EX, MEM, EX, MEM; port addresses 3, 4, 3, 4.
- mem_valid with mem_addr=0, mem_data=0x1234 -> mem_ready=1; the following port cycle has enc=0.
- iss_valid with iss_addr=7, then an EX accept to 7 in the same cycle as iss_valid with iss_addr=7 -> pending[7]=1 after both cycles (set wins); a later accept to 7 alone gives pending[7]=0.
- Assert reset during RUN in the same cycle as an accepted write to 9 -> no enc for register 9; pending=0; clear restarts at addrc=0.
